// File: rtl/shifter_pipelined_if.sv
// Handshake bundle for the pipelined barrel shifter: operation in, result out,
// plus the pipe occupancy count.
interface shifter_pipelined_if #(
  parameter int N = 32
);
  localparam int L  = $clog2(N);
  localparam int OW = $clog2(L + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [L-1:0]  in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [OW-1:0] occupancy;

  // driver side (ALU operand muxes / writeback, or a bench)
  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // shifter side
  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter: stage k shifts by 2^k when shamt[k] is set.
// One register per stage, whole pipe advances together under a global stall.
module shifter_pipelined #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst,
  shifter_pipelined_if.slave bus
);
  localparam int L  = $clog2(N);
  localparam int OW = $clog2(L + 1);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  logic          advance;

  logic [L-1:0]  vld_q;
  logic [L-1:0]  sign_q;
  logic [N-1:0]  data_q  [L];
  logic [L-1:0]  shamt_q [L];
  logic [1:0]    mode_q  [L];
  logic [OW-1:0] occ_q;

  logic [L-1:0]  st_v;
  logic [L-1:0]  st_sg;
  logic [N-1:0]  st_d [L];
  logic [L-1:0]  st_s [L];
  logic [1:0]    st_m [L];
  logic [N-1:0]  nxt_d [L];

  // SRA fill comes from the carried sign, not from the partially shifted data
  function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d,
                                               input logic        sign,
                                               input logic [1:0]  mode,
                                               input int          amt);
    logic [N-1:0] fill;
    fill = sign ? ~({N{1'b1}} >> amt) : '0;
    case (mode)
      MODE_SLL: stage_shift = d << amt;
      MODE_SRL: stage_shift = d >> amt;
      MODE_ROR: stage_shift = (d >> amt) | (d << (N - amt));
      default:  stage_shift = (d >> amt) | fill;
    endcase
  endfunction

  assign advance       = !vld_q[L-1] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[L-1];
  assign bus.out_data  = data_q[L-1];
  assign bus.occupancy = occ_q;

  always_comb begin
    st_v[0]  = bus.in_valid;
    st_sg[0] = bus.in_data[N-1];
    st_d[0]  = bus.in_data;
    st_s[0]  = bus.in_shamt;
    st_m[0]  = bus.in_mode;
    for (int k = 1; k < L; k++) begin
      st_v[k]  = vld_q[k-1];
      st_sg[k] = sign_q[k-1];
      st_d[k]  = data_q[k-1];
      st_s[k]  = shamt_q[k-1];
      st_m[k]  = mode_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < L; k++) begin
      nxt_d[k] = st_s[k][k] ? stage_shift(st_d[k], st_sg[k], st_m[k], 1 << k)
                            : st_d[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      sign_q <= '0;
      occ_q  <= '0;
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
      end
    end else if (advance) begin
      // bubbles travel like operations; they are never squeezed out
      vld_q  <= st_v;
      sign_q <= st_sg;
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= nxt_d[k];
        shamt_q[k] <= st_s[k];
        mode_q[k]  <= st_m[k];
      end
      // on an advance edge a valid output is always consumed
      case ({bus.in_valid, vld_q[L-1]})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // last stage's side-band is carried for uniformity but has no reader
  logic side_unused;
  assign side_unused = ^{shamt_q[L-1], mode_q[L-1], sign_q[L-1]};

endmodule

// File: tb/tb_shifter_pipelined.sv
// Bench for shifter_pipelined: N=8/32/64 instances checked every cycle against
// a queue-based model with per-entry remaining-advance counts.
module tb_shifter_pipelined;
  localparam logic [1:0] SLL = 2'd0;
  localparam logic [1:0] SRL = 2'd1;
  localparam logic [1:0] ROR = 2'd2;
  localparam logic [1:0] SRA = 2'd3;

  typedef struct {
    logic [63:0] d;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_t  q [3][$];
  int    acc_cnt [3];
  int    n_cmp = 0;
  int    n_bad = 0;
  string names [3] = '{"n8", "n32", "n64"};
  int    lat   [3] = '{3, 5, 6};

  shifter_pipelined_if #(.N(8))  bus8 ();
  shifter_pipelined_if #(.N(32)) bus32 ();
  shifter_pipelined_if #(.N(64)) bus64 ();

  shifter_pipelined #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  shifter_pipelined #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  shifter_pipelined #(.N(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input int n, input logic [63:0] din,
                                            input int s, input logic [1:0] m);
    logic [63:0] mask;
    logic [63:0] d;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    d = din & mask;
    case (m)
      SLL:     return (d << s) & mask;
      SRL:     return d >> s;
      ROR:     return ((d >> s) | (d << (n - s))) & mask;
      default: return d[n-1] ? ((d >> s) | (mask & ~(mask >> s))) : (d >> s);
    endcase
  endfunction

  // One cycle of the abstract model, sampled on the falling edge so it sees
  // exactly the values the next rising edge will act on.
  task automatic model_step(input int i, input int n, input logic rst_s,
                            input logic iv, input logic ir, input logic [63:0] id,
                            input int ish, input logic [1:0] im,
                            input logic ov, input logic orr, input logic [63:0] od,
                            input int occ);
    logic ev, adv;
    exp_t e;
    if (rst_s) begin
      q[i].delete();
      check({names[i], "_rst_out_valid"}, 64'(ov), 64'd0);
      check({names[i], "_rst_occupancy"}, 64'(occ), 64'd0);
      check({names[i], "_rst_out_data"}, od, 64'd0);
      check({names[i], "_rst_in_ready"}, 64'(ir), 64'd1);
      return;
    end
    ev  = (q[i].size() > 0) && (q[i][0].cnt == 0);
    adv = !ev || orr;
    check({names[i], "_out_valid"}, 64'(ov), 64'(ev));
    check({names[i], "_in_ready"}, 64'(ir), 64'(adv));
    check({names[i], "_occupancy"}, 64'(occ), 64'(q[i].size()));
    if (ev) check({names[i], "_out_data"}, od, q[i][0].d);
    if (adv) begin
      if (ev) void'(q[i].pop_front());
      for (int j = 0; j < q[i].size(); j++)
        if (q[i][j].cnt > 0) q[i][j].cnt--;
      if (iv) begin
        e.d   = ref_shift(n, id, ish, im);
        e.cnt = lat[i] - 1;
        q[i].push_back(e);
        acc_cnt[i]++;
      end
    end
  endtask

  always @(negedge clk)
    model_step(0, 8, rst, bus8.in_valid, bus8.in_ready, 64'(bus8.in_data),
               int'(bus8.in_shamt), bus8.in_mode, bus8.out_valid, bus8.out_ready,
               64'(bus8.out_data), int'(bus8.occupancy));
  always @(negedge clk)
    model_step(1, 32, rst, bus32.in_valid, bus32.in_ready, 64'(bus32.in_data),
               int'(bus32.in_shamt), bus32.in_mode, bus32.out_valid, bus32.out_ready,
               64'(bus32.out_data), int'(bus32.occupancy));
  always @(negedge clk)
    model_step(2, 64, rst, bus64.in_valid, bus64.in_ready, bus64.out_data & 64'd0 | 64'(bus64.in_data),
               int'(bus64.in_shamt), bus64.in_mode, bus64.out_valid, bus64.out_ready,
               64'(bus64.out_data), int'(bus64.occupancy));

  task automatic set_op32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    bus32.in_valid = 1'b1;
    bus32.in_data  = d;
    bus32.in_shamt = s;
    bus32.in_mode  = m;
  endtask

  task automatic rand_op32(output logic [31:0] expv);
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  m;
    d = $urandom();
    s = 5'($urandom_range(0, 31));
    m = 2'($urandom_range(0, 3));
    set_op32(d, s, m);
    expv = 32'(ref_shift(32, 64'(d), int'(s), m));
  endtask

  task automatic single_op32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                             input logic [31:0] expv, input string nm);
    int edges;
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    set_op32(d, s, m);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    edges = 1;
    while (!bus32.out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({nm, "_latency"}, 64'(edges), 64'd5);
    check({nm, "_data"}, 64'(bus32.out_data), 64'(expv));
  endtask

  task automatic wait_drain(input int i);
    int c;
    c = 0;
    while (q[i].size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check({names[i], "_drain"}, 64'(q[i].size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_exp, dummy;
    int acc, cyc;
    logic took;

    rst = 1'b1;
    bus8.in_valid  = 1'b0; bus8.in_data  = '0; bus8.in_shamt  = '0; bus8.in_mode  = '0; bus8.out_ready  = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_shamt = '0; bus32.in_mode = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_data = '0; bus64.in_shamt = '0; bus64.in_mode = '0; bus64.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // hand-computed pins on the reference model itself
    check("model_ror8", ref_shift(8, 64'h81, 1, ROR), 64'hC0);
    check("model_sra8", ref_shift(8, 64'h90, 2, SRA), 64'hE4);
    check("model_sll64", ref_shift(64, 64'd1, 63, SLL), 64'h8000_0000_0000_0000);
    check("model_sra64", ref_shift(64, 64'h8000_0000_0000_0000, 63, SRA), 64'hFFFF_FFFF_FFFF_FFFF);

    single_op32(32'h8000_0000, 5'd31, SRL, 32'h0000_0001, "srl31");
    single_op32(32'h0000_0001, 5'd31, SLL, 32'h8000_0000, "sll31");
    single_op32(32'h8000_0000, 5'd4,  SRA, 32'hF800_0000, "sra_neg");
    single_op32(32'h7FFF_FFF0, 5'd4,  SRA, 32'h07FF_FFFF, "sra_pos");
    single_op32(32'h0000_0001, 5'd1,  ROR, 32'h8000_0000, "ror1");
    single_op32(32'hDEAD_BEEF, 5'd0,  SLL, 32'hDEAD_BEEF, "id_sll");
    single_op32(32'hDEAD_BEEF, 5'd0,  SRL, 32'hDEAD_BEEF, "id_srl");
    single_op32(32'hDEAD_BEEF, 5'd0,  ROR, 32'hDEAD_BEEF, "id_ror");
    single_op32(32'hDEAD_BEEF, 5'd0,  SRA, 32'hDEAD_BEEF, "id_sra");
    wait_drain(1);

    // back-to-back stream of 8
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_op32(dummy);
      @(posedge clk); #1;
      if (i + 1 >= 5) begin
        check("b2b_occupancy", 64'(bus32.occupancy), 64'd5);
        check("b2b_out_valid", 64'(bus32.out_valid), 64'd1);
      end
    end
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("b2b_tail_valid", 64'(bus32.out_valid), 64'd1);
    end
    wait_drain(1);

    // backpressure: fill with out_ready low, then hold 10 cycles
    bus32.out_ready = 1'b0;
    rand_op32(first_exp);
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 20) begin
      @(negedge clk); took = bus32.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        acc++;
        rand_op32(dummy);
      end
    end
    check("bp_fill_count", 64'(acc), 64'd5);
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus32.out_valid), 64'd1);
      check("bp_hold_data", 64'(bus32.out_data), 64'(first_exp));
      check("bp_occupancy", 64'(bus32.occupancy), 64'd5);
    end
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    cyc = 0;
    while (acc < 8 && cyc < 20) begin
      @(negedge clk); took = bus32.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        acc++;
        if (acc < 8) rand_op32(dummy);
      end
    end
    bus32.in_valid = 1'b0;
    wait_drain(1);

    // reset with three operations in flight and a result on the output
    bus32.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_op32(dummy);
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b0;
    cyc = 0;
    while (!bus32.out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_rst_out_valid", 64'(bus32.out_valid), 64'd1);
    check("pre_rst_occupancy", 64'(bus32.occupancy), 64'd3);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("async_rst_occupancy", 64'(bus32.occupancy), 64'd0);
    check("async_rst_out_data", 64'(bus32.out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus32.out_ready = 1'b1;
    single_op32(32'h0000_F000, 5'd12, SRL, 32'h0000_000F, "post_rst");
    wait_drain(1);

    // randomized traffic on all three widths
    acc_cnt[0] = 0; acc_cnt[1] = 0; acc_cnt[2] = 0;
    fork
      begin
        logic [63:0] r8;
        int c8;
        c8 = 0;
        while (acc_cnt[0] < 2000 && c8 < 30000) begin
          @(posedge clk); #1;
          c8++;
          r8 = {$urandom(), $urandom()};
          bus8.in_valid  = ($urandom_range(0, 3) != 0);
          bus8.in_data   = r8[7:0];
          bus8.in_shamt  = 3'($urandom_range(0, 7));
          bus8.in_mode   = 2'($urandom_range(0, 3));
          bus8.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
      end
      begin
        logic [63:0] r32;
        int c32;
        c32 = 0;
        while (acc_cnt[1] < 600 && c32 < 30000) begin
          @(posedge clk); #1;
          c32++;
          r32 = {$urandom(), $urandom()};
          bus32.in_valid  = ($urandom_range(0, 2) != 0);
          bus32.in_data   = r32[31:0];
          bus32.in_shamt  = 5'($urandom_range(0, 31));
          bus32.in_mode   = 2'($urandom_range(0, 3));
          bus32.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      end
      begin
        logic [63:0] r64;
        int c64;
        c64 = 0;
        while (acc_cnt[2] < 2000 && c64 < 30000) begin
          @(posedge clk); #1;
          c64++;
          r64 = {$urandom(), $urandom()};
          bus64.in_valid  = ($urandom_range(0, 3) != 0);
          bus64.in_data   = r64;
          bus64.in_shamt  = 6'($urandom_range(0, 63));
          bus64.in_mode   = 2'($urandom_range(0, 3));
          bus64.out_ready = ($urandom_range(0, 4) != 0);
        end
        bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
      end
    join
    wait_drain(0);
    wait_drain(1);
    wait_drain(2);
    check("n8_ops_done",  64'(acc_cnt[0] >= 2000), 64'd1);
    check("n32_ops_done", 64'(acc_cnt[1] >= 600),  64'd1);
    check("n64_ops_done", 64'(acc_cnt[2] >= 2000), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shifter_pipelined.md
Name: shifter_pipelined

Overview:
- Parametrised, pipelined barrel shifter. Successor to the fixed 32-bit combinational logical-right shifter.
- Adds four modes (SLL, SRL, SRA, ROR), any power-of-two width N, one register per shift stage, and a valid/ready handshake with full backpressure.
- Sits between the ALU operand muxes and the writeback stage of the multicycle core.
- Accepts one operation per cycle when unstalled.

Parameters:
- N, 32: data width; must be a power of two, at least 2.
- L, $clog2(N): number of pipeline stages, equal to the shamt width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream has an operation
- in_ready  output  1  block can accept this cycle
- in_data  input  N  operand
- in_shamt  input  L  shift amount, 0..N-1
- in_mode  input  2  00=SLL, 01=SRL, 10=ROR, 11=SRA
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream consumes this cycle
- out_data  output  N  shifted result
- occupancy  output  $clog2(L+1)  number of valid entries in the pipe, 0..L

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, data, shamt and mode registers clear to 0 immediately.
  - out_valid=0, out_data=0, occupancy=0, in_ready=1 while rst is low again.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Stage k (k=0..L-1):
  - Combinationally applies a shift of 2^k to its input iff shamt[k]=1, using the mode carried with the operation.
  - Registers the result together with the valid bit, shamt and mode.
  - Stage 0 takes in_data/in_shamt/in_mode. Stage L-1's registers drive out_data/out_valid directly.
- Mode rules:
  - SLL fills vacated bits with 0.
  - SRL fills vacated bits with 0.
  - SRA fills vacated bits with the operand's original bit N-1, carried as a sign bit through every stage.
  - ROR wraps the bits shifted out of bit 0 into bit N-1.
  - shamt=0 passes in_data unchanged in every mode.
- Handshake:
  - Global stall signal: advance = !out_valid || out_ready.
  - in_ready = advance. This is combinational from out_valid/out_ready only, never from in_valid.
  - Accept occurs on a rising edge with in_valid && in_ready. On that edge stage 0 loads the operation with valid=1.
  - On an advance edge with in_valid=0, stage 0 loads valid=0 (a bubble).
  - All stages shift forward together on every edge where advance=1. All stages hold when advance=0.
  - Bubbles are not squeezed out.
  - out_data and out_valid are stable while out_valid=1 && out_ready=0.
- Latency and throughput:
  - An operation accepted on edge E appears at the output (out_valid=1) after edge E+L-1 with no stall. That is L edges counting E; for N=32 this is 5.
  - Each stall cycle adds one cycle of latency.
  - Throughput is 1 per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order. No drop or duplication under any in_valid/out_ready pattern.
- occupancy:
  - Registered population count of the stage valid bits.
  - Updated on the same edges as the pipe: +1 when a valid operation enters, -1 when a valid result is consumed, net 0 when both happen.
  - Never exceeds L.
- Out of scope: in_shamt values >= N cannot be represented; no handling required.
- Simultaneous events: accept and consume on the same edge are both legal and both take effect.

Test Plan:
- Reset, then single ops, N=32, out_ready=1:
  - SRL 0x80000000 shamt 31 -> 0x00000001, exactly 5 edges after accept.
  - SLL 0x00000001 shamt 31 -> 0x80000000.
- Sign fill, rotate and identity:
  - SRA 0x80000000 shamt 4 -> 0xF8000000.
  - SRA 0x7FFFFFF0 shamt 4 -> 0x07FFFFFF.
  - ROR 0x00000001 shamt 1 -> 0x80000000.
  - shamt 0 in all four modes with 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back stream of 8 random ops with in_valid=1 and out_ready=1:
  - One result per cycle after the 5-cycle fill.
  - Results in order and matching the reference model; occupancy reads 5 in steady state.
- Backpressure: fill the pipe, then drop out_ready for 10 cycles:
  - in_ready=0 throughout, out_data held constant, occupancy=5.
  - Raise out_ready: results drain in order with no loss or duplication.
- Random in_valid/out_ready patterns with N=8 and N=64 builds, 2000 ops each -> scoreboard match, zero mismatches.
- Assert rst for 1 cycle with 3 ops in flight and out_valid=1:
  - out_valid=0, occupancy=0, out_data=0 immediately.
  - The next accepted op completes correctly after L edges.
